// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the SRAM read-modify-write controller.
package mem_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        StIdle,
        StMerge
    } state_e;

    // Byte-lane merge: take the new byte where its enable is set, else keep the old one.
    function automatic logic [BYTE_W-1:0] be_merge(
        input logic [BYTE_W-1:0] old_byte,
        input logic [BYTE_W-1:0] new_byte,
        input logic              be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/sram_sp.sv
// Behavioural single-port SRAM: active-low CEN/WEN, Q updates only on a read and holds otherwise.
module sram_sp #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 7
) (
    output logic [DATA_W-1:0] Q,
    input  logic              CLK,
    input  logic              CEN,
    input  logic              WEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array write or registered read, only when the macro is enabled.
    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (!WEN) begin
                mem[A] <= D;
            end else begin
                Q <= mem[A];
            end
        end
    end

endmodule

// File: rtl/sram_rmw_ctrl.sv
// Valid/ready front end over a word-write SRAM; partial writes become read-modify-write.
module sram_rmw_ctrl import mem_ctrl_pkg::*; #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 128,
    localparam int unsigned BE_W  = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [ADDR_W:0] DepthC = DEPTH[ADDR_W:0];

    state_e            state_q, state_d;
    logic              init_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_err_q, rd_err_d;
    logic              rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic              sram_cen_n, sram_wen_n;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata, sram_q, merged;
    logic              accept, in_range, be_full, be_none;

    assign req_ready = (state_q == StIdle) & init_q;
    assign accept    = req_valid & req_ready;
    assign in_range  = {1'b0, req_addr} < DepthC;
    assign be_full   = &req_be;
    assign be_none   = ~|req_be;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Per-lane merge of latched write data over the word read in the accept cycle.
    always_comb begin
        merged = '0;
        for (int i = 0; i < BE_W; i++) begin
            merged[i*BYTE_W +: BYTE_W] = be_merge(sram_q[i*BYTE_W +: BYTE_W],
                                                  wdata_q[i*BYTE_W +: BYTE_W], be_q[i]);
        end
    end

    // Next state and SRAM command decode.
    always_comb begin
        state_d    = state_q;
        rd_pend_d  = 1'b0;
        rd_err_d   = 1'b0;
        sram_cen_n = 1'b1;
        sram_wen_n = 1'b1;
        sram_addr  = req_addr;
        sram_wdata = req_wdata;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!req_we) begin
                        if (in_range) begin
                            sram_cen_n = 1'b0;
                            rd_pend_d  = 1'b1;
                        end else begin
                            rd_err_d = 1'b1;
                        end
                    end else if (in_range && !be_none) begin
                        sram_cen_n = 1'b0;
                        if (be_full) begin
                            sram_wen_n = 1'b0;
                        end else begin
                            state_d = StMerge;
                        end
                    end
                end
            end
            StMerge: begin
                sram_cen_n = 1'b0;
                sram_wen_n = 1'b0;
                sram_addr  = addr_q;
                sram_wdata = merged;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // A reset cycle must never touch the array, including an in-flight merge.
        if (!rst_n) begin
            sram_cen_n = 1'b1;
        end
    end

    // Control state and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            init_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_err_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            init_q      <= 1'b1;
            rd_pend_q   <= rd_pend_d;
            rd_err_q    <= rd_err_d;
            rsp_valid_q <= rd_pend_q | rd_err_q;
            if (rd_pend_q | rd_err_q) begin
                rsp_err_q   <= rd_err_q;
                rsp_rdata_q <= rd_pend_q ? sram_q : '0;
            end
        end
    end

    // Capture the request for a possible merge cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    sram_sp #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_sram (
        .Q  (sram_q),
        .CLK(clk),
        .CEN(sram_cen_n),
        .WEN(sram_wen_n),
        .A  (sram_addr),
        .D  (sram_wdata)
    );

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// Directed bench for sram_rmw_ctrl, built with DEPTH=100 so out-of-range addresses exist.
module tb_sram_rmw_ctrl;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DEPTH  = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [1:0]        req_be = '0;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_rmw_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    // Present a request, wait (bounded) for ready, and return 1 time unit after the accept edge.
    task automatic issue(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [1:0] be);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        while (!req_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready_timeout addr=%0d: ready=%b, required 1", a, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready: got %b, required 0", req_ready);
            end
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid);
            end
            checks++;
            if (rsp_rdata !== 16'h0000) begin
                errors++;
                $display("FAIL reset_rsp_rdata: got %h, required 0000", rsp_rdata);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL release_ready_early: got %b, required 0", req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready_late: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_full_write_read();
        issue(1'b1, 7'd5, 16'hBEEF, 2'b11);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_write_ready: got %b, required 1", req_ready);
        end
        issue(1'b0, 7'd5, 16'h0000, 2'b00);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_latency_early: rsp_valid=%b, required 0", rsp_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hBEEF || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL full_read_rsp: valid=%b data=%h err=%b, required 1 BEEF 0",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL rsp_pulse_hold: valid=%b data=%h, required 0 BEEF", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_partial_write();
        issue(1'b1, 7'd5, 16'h1234, 2'b01);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL merge_ready: got %b, required 0", req_ready);
        end
        // Read straight after the merge: must see merged data.
        issue(1'b0, 7'd5, 16'h0000, 2'b00);
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hBE34) begin
            errors++;
            $display("FAIL partial_lo: valid=%b data=%h, required 1 BE34", rsp_valid, rsp_rdata);
        end
        issue(1'b1, 7'd5, 16'hAB00, 2'b10);
        issue(1'b0, 7'd5, 16'h0000, 2'b00);
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hAB34) begin
            errors++;
            $display("FAIL partial_hi: valid=%b data=%h, required 1 AB34", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] exp_d;
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, ADDR_W'(i), DATA_W'(i * 3), 2'b11);
        end
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, ADDR_W'(i), 16'h0000, 2'b00);
            if (i > 0) begin
                exp_d = DATA_W'((i - 1) * 3);
                checks++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d) begin
                    errors++;
                    $display("FAIL stream_rsp[%0d]: valid=%b data=%h, required 1 %h",
                             i - 1, rsp_valid, rsp_rdata, exp_d);
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'd21) begin
            errors++;
            $display("FAIL stream_rsp[7]: valid=%b data=%h, required 1 0015", rsp_valid, rsp_rdata);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: valid=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_out_of_range();
        issue(1'b0, 7'd120, 16'h0000, 2'b00);
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL oor_read: valid=%b err=%b data=%h, required 1 1 0000",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        // Out-of-range write: accepted without any array enable.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 7'd120;
        req_wdata = 16'hDEAD;
        req_be    = 2'b11;
        #1;
        checks++;
        if (req_ready !== 1'b1 || dut.sram_cen_n !== 1'b1) begin
            errors++;
            $display("FAIL oor_write_cen: ready=%b cen_n=%b, required 1 1", req_ready, dut.sram_cen_n);
        end
        @(posedge clk);
        #1;
        // Zero byte-enable write: dropped, memory unchanged.
        req_addr  = 7'd3;
        req_wdata = 16'hFFFF;
        req_be    = 2'b00;
        #1;
        checks++;
        if (dut.sram_cen_n !== 1'b1) begin
            errors++;
            $display("FAIL be0_write_cen: cen_n=%b, required 1", dut.sram_cen_n);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        issue(1'b0, 7'd3, 16'h0000, 2'b00);
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 16'h0009) begin
            errors++;
            $display("FAIL be0_unchanged: valid=%b err=%b data=%h, required 1 0 0009",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        // Boundary: last implemented word works, DEPTH itself is out of range.
        issue(1'b1, 7'd99, 16'h5A5A, 2'b11);
        issue(1'b0, 7'd99, 16'h0000, 2'b00);
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 16'h5A5A) begin
            errors++;
            $display("FAIL last_word: valid=%b err=%b data=%h, required 1 0 5A5A",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        issue(1'b0, 7'd100, 16'h0000, 2'b00);
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL depth_addr: valid=%b err=%b data=%h, required 1 1 0000",
                     rsp_valid, rsp_err, rsp_rdata);
        end
    endtask

    task automatic test_reset_in_merge();
        issue(1'b1, 7'd6, 16'hFFFF, 2'b10);
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut.sram_cen_n !== 1'b1) begin
            errors++;
            $display("FAIL merge_abort_cen: cen_n=%b, required 1", dut.sram_cen_n);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (req_ready !== 1'b0 || rsp_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL merge_abort_state: ready=%b data=%h, required 0 0000", req_ready, rsp_rdata);
        end
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL merge_abort_ready: got %b, required 1", req_ready);
        end
        issue(1'b0, 7'd6, 16'h0000, 2'b00);
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0012) begin
            errors++;
            $display("FAIL merge_abort_data: valid=%b data=%h, required 1 0012", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_lost_response();
        issue(1'b0, 7'd5, 16'h0000, 2'b00);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL lost_rsp_valid: got %b, required 0", rsp_valid);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL lost_rsp_after: valid=%b ready=%b, required 0 1", rsp_valid, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_stream();
        test_out_of_range();
        test_reset_in_merge();
        test_lost_response();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
